// File: rtl/bf16_acc_seq.sv
// Sequences a run of BF16 elements through an external pipelined adder and
// returns the accumulated sum; the block itself never touches the data bits.
module bf16_acc_seq #(
    parameter int SIZE_DATA = 16,
    parameter int CNT_W     = 8,
    parameter int ADD_LAT   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_len,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_ready,
    output logic [SIZE_DATA-1:0] o_add_a,
    output logic [SIZE_DATA-1:0] o_add_b,
    input  logic [SIZE_DATA-1:0] i_add_s,
    output logic                 o_valid,
    output logic [SIZE_DATA-1:0] o_sum,
    input  logic                 i_out_ready,
    output logic                 o_busy
);
    // state  | meaning
    // S_IDLE | waiting for i_start, run length latched on start
    // S_LOAD | accepting next element, issues adder operands
    // S_WAIT | adder in flight, sum sampled when wait counter hits zero
    // S_DONE | o_sum presented until i_out_ready

    localparam int WCNT_W = $clog2(ADD_LAT + 2);
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(ADD_LAT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      rem_q, rem_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [SIZE_DATA-1:0]  acc_q, acc_d;
    logic [SIZE_DATA-1:0]  add_a_q, add_a_d;
    logic [SIZE_DATA-1:0]  add_b_q, add_b_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            wcnt_q  <= '0;
            acc_q   <= '0;
            add_a_q <= '0;
            add_b_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            acc_q   <= acc_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    rem_d   = i_len;
                    acc_d   = '0;
                    state_d = (i_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    add_a_d = acc_q;
                    add_b_d = i_data;
                    wcnt_d  = WAIT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // the counter expires on the edge ADD_LAT+1 after issue
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    acc_d = i_add_s;
                    if (rem_q != '0)
                        rem_d = rem_q - 1'b1;
                    state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_add_a = add_a_q;
    assign o_add_b = add_b_q;
    assign o_sum   = acc_q;
    assign o_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_bf16_acc_seq.sv
// Bench for bf16_acc_seq: two-stage BF16 adder model, table of runs with a
// result scoreboard, plus a hand-written reset-abort sequence.
module tb_bf16_acc_seq;
    localparam int SD = 16;
    localparam int CW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_len = '0;
    logic          i_valid = 1'b0;
    logic [SD-1:0] i_data = '0;
    logic          o_ready;
    logic [SD-1:0] o_add_a;
    logic [SD-1:0] o_add_b;
    logic [SD-1:0] i_add_s;
    logic          o_valid;
    logic [SD-1:0] o_sum;
    logic          i_out_ready = 1'b0;
    logic          o_busy;

    bf16_acc_seq #(.SIZE_DATA(SD), .CNT_W(CW), .ADD_LAT(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .o_add_a(o_add_a), .o_add_b(o_add_b), .i_add_s(i_add_s),
        .o_valid(o_valid), .o_sum(o_sum), .i_out_ready(i_out_ready),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Positive-normal BF16 add with truncation; exact for the values used here.
    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [7:0]  d, mx, my, e;
        logic [8:0]  s;
        if (a[14:0] == 15'd0) return b;
        if (b[14:0] == 15'd0) return a;
        if (a[14:7] >= b[14:7]) begin x = a; y = b; end
        else begin x = b; y = a; end
        d  = x[14:7] - y[14:7];
        mx = {1'b1, x[6:0]};
        my = (d > 8'd7) ? 8'h00 : ({1'b1, y[6:0]} >> d);
        s  = {1'b0, mx} + {1'b0, my};
        e  = x[14:7];
        if (s[8]) begin e = e + 8'd1; s = s >> 1; end
        return {1'b0, e, s[6:0]};
    endfunction

    logic [15:0] s1_q = '0, add_s_q = '0;
    always @(posedge i_clk) begin
        s1_q    <= bf16_add(o_add_a, o_add_b);
        add_s_q <= s1_q;
    end
    assign i_add_s = add_s_q;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb[$];

    int          nb_chg = 0;
    logic [15:0] prev_b = '0;
    logic [15:0] a_hist[$];
    always @(negedge i_clk) begin
        if (o_add_b !== prev_b) begin
            nb_chg++;
            a_hist.push_back(o_add_a);
        end
        prev_b = o_add_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int              len;
        logic [3:0][15:0] el;
        int              gap;
        int              hold;
        bit              noise;
        logic [15:0]     exp_sum;
    } tv_t;

    // Called at a negedge; returns at a negedge with the block back in IDLE.
    task automatic do_run(input tv_t v, input string tag);
        int          k, idx, gapc, per, exp_lat;
        bit          done;
        logic [15:0] exp;
        sb.push_back(v.exp_sum);
        nb_chg = 0;
        a_hist.delete();
        per     = (v.gap + 1 > 4) ? v.gap + 1 : 4;
        exp_lat = (v.len == 0) ? 0 : (v.gap + 1) + (v.len - 1) * per + 3;
        i_start = 1'b1;
        i_len   = CW'(v.len);
        @(negedge i_clk);
        i_start = 1'b0;
        k = 0; idx = 0; gapc = v.gap; done = 0;
        while (!done && k < 400) begin
            if (o_valid) begin
                done = 1;
            end else begin
                i_start = v.noise && (k % 3 == 1);
                if (idx < v.len && gapc == 0) begin
                    i_valid = 1'b1;
                    i_data  = v.el[idx];
                    if (o_ready) begin idx++; gapc = v.gap; end
                end else begin
                    i_valid = 1'b0;
                    i_data  = 16'hFFFF;
                    if (gapc > 0) gapc--;
                end
                @(negedge i_clk);
                k++;
            end
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        exp = sb.pop_front();
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: no o_valid within 400 cycles, expected sum %h", tag, exp);
        end else begin
            check({tag, " latency"}, k, exp_lat);
            check({tag, " sum"}, o_sum, exp);
            check({tag, " handshakes"}, idx, v.len);
            check({tag, " add_b updates"}, nb_chg, v.len);
            for (int h = 0; h < v.hold; h++) begin
                i_out_ready = 1'b0;
                i_start     = v.noise;
                @(negedge i_clk);
                check({tag, " hold valid"}, o_valid, 1'b1);
                check({tag, " hold sum"}, o_sum, exp);
            end
            i_start     = 1'b0;
            i_out_ready = 1'b1;
            @(negedge i_clk);
            i_out_ready = 1'b0;
            check({tag, " valid after accept"}, o_valid, 1'b0);
            check({tag, " busy after accept"}, o_busy, 1'b0);
        end
    endtask

    tv_t vec[6];

    initial begin
        tv_t r;
        vec[0] = '{len:3, el:{16'h0000, 16'h4040, 16'h4000, 16'h3F80}, gap:0, hold:0, noise:1'b0, exp_sum:16'h40C0};
        vec[1] = '{len:0, el:{16'h0000, 16'h0000, 16'h0000, 16'h0000}, gap:0, hold:1, noise:1'b0, exp_sum:16'h0000};
        vec[2] = '{len:2, el:{16'h0000, 16'h0000, 16'h4100, 16'h4080}, gap:5, hold:0, noise:1'b0, exp_sum:16'h4140};
        vec[3] = '{len:1, el:{16'h0000, 16'h0000, 16'h0000, 16'h3F00}, gap:0, hold:6, noise:1'b1, exp_sum:16'h3F00};
        vec[4] = '{len:4, el:{16'h4100, 16'h4080, 16'h4000, 16'h3F80}, gap:1, hold:2, noise:1'b0, exp_sum:16'h4170};
        vec[5] = '{len:2, el:{16'h0000, 16'h0000, 16'h3F00, 16'h3E80}, gap:2, hold:3, noise:1'b1, exp_sum:16'h3F40};

        repeat (3) @(negedge i_clk);
        check("reset ready", o_ready, 1'b0);
        check("reset valid", o_valid, 1'b0);
        check("reset busy", o_busy, 1'b0);
        check("reset add_a", o_add_a, 16'h0000);
        check("reset add_b", o_add_b, 16'h0000);
        check("reset sum", o_sum, 16'h0000);
        i_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_run(vec[i], $sformatf("run%0d", i));
            if (i == 0) begin
                check("run0 add_a count", a_hist.size(), 3);
                if (a_hist.size() == 3) begin
                    check("run0 add_a[0]", a_hist[0], 16'h0000);
                    check("run0 add_a[1]", a_hist[1], 16'h3F80);
                    check("run0 add_a[2]", a_hist[2], 16'h4040);
                end
            end
        end

        // reset during WAIT of a len=4 run
        i_len   = 8'd4;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_valid = 1'b1;
        i_data  = 16'h4000;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("abort in wait busy", o_busy, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check("abort ready", o_ready, 1'b0);
        check("abort valid", o_valid, 1'b0);
        check("abort busy", o_busy, 1'b0);
        check("abort add_a", o_add_a, 16'h0000);
        check("abort add_b", o_add_b, 16'h0000);
        check("abort sum", o_sum, 16'h0000);
        @(negedge i_clk);
        check("abort valid held", o_valid, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        r = '{len:1, el:{16'h0000, 16'h0000, 16'h0000, 16'h3F80}, gap:0, hold:0, noise:1'b0, exp_sum:16'h3F80};
        do_run(r, "post-reset");

        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bf16_acc_seq.md
BF16_ACC_SEQ -- requirements
Module: bf16_acc_seq

Interface
REQ-001 Parameter SIZE_DATA, default 16, BF16 word width.
REQ-002 Parameter CNT_W, default 8, width of the element-count input; max run length 2^CNT_W-1.
REQ-003 Parameter ADD_LAT, default 2, register stages inside the downstream BF16 adder (input reg + output reg).
REQ-004 i_clk  input  1  clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  start pulse for one accumulation run; sampled only in IDLE.
REQ-007 i_len  input  CNT_W  number of BF16 elements in the run; latched on accepted i_start.
REQ-008 i_valid  input  1  upstream element valid.
REQ-009 i_data  input  SIZE_DATA  upstream BF16 element.
REQ-010 o_ready  output  1  element accept; transfer when i_valid && o_ready at a rising edge.
REQ-011 o_add_a  output  SIZE_DATA  adder operand A (running sum), registered.
REQ-012 o_add_b  output  SIZE_DATA  adder operand B (current element), registered.
REQ-013 i_add_s  input  SIZE_DATA  adder result.
REQ-014 o_valid  output  1  final sum valid.
REQ-015 o_sum  output  SIZE_DATA  final BF16 sum.
REQ-016 i_out_ready  input  1  downstream accept of o_sum.
REQ-017 o_busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, LOAD, WAIT, DONE; one-hot or binary encoding is free.
REQ-019 IDLE: o_ready=0; on i_start=1, latch i_len into remaining counter, clear acc to 16'h0000; go DONE if i_len==0, else LOAD.
REQ-020 LOAD: o_ready=1; on i_valid handshake, register o_add_a<=acc and o_add_b<=i_data, load wait counter, go WAIT; with i_valid=0, stay in LOAD and hold all registers.
REQ-021 WAIT: o_ready=0; o_add_a/o_add_b held stable; i_add_s sampled exactly ADD_LAT+1 rising edges after the edge that updated o_add_a/o_add_b.
REQ-022 At the sampling edge: acc<=i_add_s, remaining<=remaining-1; next state DONE if remaining was 1, else LOAD.
REQ-023 Minimum spacing between accepted elements is ADD_LAT+2 cycles (4 at default); no element is issued before the previous result has been sampled.
REQ-024 DONE: o_valid=1, o_sum=acc; hold both stable until i_out_ready=1 at an edge, then go IDLE with o_valid=0 in the next cycle.
REQ-025 i_start outside IDLE is ignored; i_valid outside LOAD is ignored and not consumed.
REQ-026 Block performs no arithmetic on data; the sum is exactly the adder output chain, including rounding, NaN and Inf propagation.
REQ-027 i_len==0 run: o_valid rises one cycle after the start edge with o_sum=16'h0000; no adder operand update occurs.
REQ-028 Counter widths: remaining is CNT_W bits and never wraps (decrement only from a nonzero value); wait counter is ceil(log2(ADD_LAT+2)) bits.

Reset
REQ-029 While i_rst_n=0, immediately: state=IDLE; o_ready, o_valid, o_busy=0; o_add_a, o_add_b, o_sum, acc, counters=0.
REQ-030 Reset asserted mid-run (LOAD/WAIT/DONE) aborts the run; no o_valid pulse follows; in-flight adder result is discarded.
REQ-031 First i_start accepted at the first rising edge after i_rst_n deasserts.

Verification
REQ-032 len=3, elements 3F80, 4000, 4040 streamed with i_valid held high; bench adder model with ADD_LAT=2 -> o_add_a sequence 0000, 3F80, 4040; o_sum=40C0; o_valid 12 cycles after the start edge (3 elements x 4 cycles).
REQ-033 len=0 -> o_valid=1 and o_sum=0000 in the cycle after the start edge; o_add_a/o_add_b remain 0000.
REQ-034 len=2 with 5-cycle gaps on i_valid -> no handshake while i_valid=0; o_add_b changes exactly twice; o_sum correct.
REQ-035 Run completes with i_out_ready=0 for 6 cycles -> o_valid and o_sum stable for 6 cycles; IDLE and o_busy=0 on the cycle after i_out_ready=1; i_start pulses during the run and hold are ignored.
REQ-036 i_rst_n pulsed low during WAIT of a len=4 run -> all outputs 0 during reset; no o_valid; a new len=1 run with 3F80 afterwards yields o_sum=3F80.
